updown_mod_counter: RTL and testbench
=====================================

// Module: updown_mod_counter
// PURPOSE
//  Parametrised up/down counter with an optional enable-qualified prescaler.
//  Features: synchronous load, programmable modulo limit, wrap or saturate mode,
//  terminal-count pulse and sticky overflow flag.
//  General-purpose counter for timers, address generators and event counting.
//  Successor to the fixed 4-bit up counter.
// PARAMETERS
//  WIDTH      8               counter width in bits (>=2)
//  MAX_VAL    2**WIDTH-1      upper count limit; range is 0..MAX_VAL
//  RESET_VAL  0               count value after reset (must be <= MAX_VAL)
//  PRESCALE   1               enabled cycles per count step (>=1; 1 = every cycle)
// PORTS
//  clk       in   1      clock, rising edge
//  rst       in   1      reset, synchronous, active-high
//  en        in   1      count enable; also advances the prescaler
//  up_dn     in   1      1 = count up, 0 = count down
//  sat_mode  in   1      0 = wrap at limits, 1 = saturate at limits
//  load      in   1      synchronous load strobe
//  load_val  in   WIDTH  load value; clamped to MAX_VAL
//  clr_ovf   in   1      clears the sticky ovf flag
//  count     out  WIDTH  current count, registered
//  tc        out  1      terminal-count pulse, registered, one cycle
//  ovf       out  1      sticky overflow/underflow flag, registered
//  zero      out  1      combinational, count == 0
// BEHAVIOUR
//  Reset state: count=RESET_VAL, tc=0, ovf=0, prescaler=0.
//  Priority per edge: rst > load > step.
//  Load:
//   - count <= min(load_val, MAX_VAL); prescaler <= 0; tc <= 0.
//   - ovf is unaffected except by clr_ovf.
//  Step condition: step = en & tick & ~load.
//  Prescaler:
//   - Increments on each en cycle; wraps to 0 after PRESCALE-1.
//   - tick = en & (presc == PRESCALE-1); holds value when en=0.
//   - For PRESCALE=1 the prescaler is removed and tick = en.
//  Up step:
//   - count<MAX_VAL -> count+1.
//   - count==MAX_VAL -> 0 (wrap) or MAX_VAL (sat).
//  Down step:
//   - count>0 -> count-1.
//   - count==0 -> MAX_VAL (wrap) or 0 (sat).
//  Boundary step: a step taken while at the limit in the current direction.
//   - Up at MAX_VAL, or down at 0.
//   - Next cycle: tc=1 for exactly one cycle; ovf <= 1.
//   - Applies in both wrap and sat mode; each held saturated step re-pulses tc.
//   - tc=0 on all other cycles.
//  ovf: cleared by clr_ovf; a boundary step in the same cycle as clr_ovf wins (ovf=1).
//  up_dn and sat_mode are sampled only on step cycles; may change any cycle.
//  No step occurs when en=0; count, prescaler and ovf hold.
//  Reset mid-count or mid-prescale returns every register to its reset value next edge.
//  Width rules: all arithmetic in WIDTH bits; MAX_VAL < 2**WIDTH; no carry-out port.
// STRUCTURE
//  Package counter_pkg: localparams CNT_UP=1'b1, CNT_DN=1'b0, MODE_WRAP=1'b0, MODE_SAT=1'b1.
//  Sub-module tick_prescaler (param PRESCALE; ports clk, rst, en, clr, tick):
//   - clr is driven by load.
//   - Instantiated only when PRESCALE>1 (generate); otherwise tick = en.
//  Top level: clamp logic, next-count mux, tc/ovf registers.
// TESTING
//  1. Defaults WIDTH=4, MAX_VAL=15, up, wrap; rst 1 cycle then en=1:
//     count 0,1,..,15,0; tc=1 the cycle after 15->0; ovf=1 thereafter.
//  2. MAX_VAL=9, down, sat; load_val=2 then en=1:
//     count 2,1,0,0,0; tc pulses on each held step at 0; zero=1.
//  3. load_val=200 with MAX_VAL=9 -> count=9.
//     load and en in the same cycle -> load wins, no step, no tc.
//  4. PRESCALE=3, en=1 -> count advances every 3rd cycle.
//     Drop en for 2 cycles mid-prescale -> phase held; load resets phase.
//  5. At MAX_VAL, up step with clr_ovf=1 in the same cycle -> ovf stays 1.
//     Next cycle clr_ovf alone -> ovf=0.
//  6. Assert rst mid-count (count=7, presc=1) with en=1 -> next edge:
//     count=RESET_VAL, tc=0, ovf=0, presc=0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down modulo counter.
// Direction and limit-mode encodings match the up_dn and sat_mode inputs.
package counter_pkg;

   localparam logic CNT_UP    = 1'b1;
   localparam logic CNT_DN    = 1'b0;
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   // Unsigned min(): used to clamp load values to the counter's upper limit.
   function automatic int unsigned clamp_to(input int unsigned val, input int unsigned lim);
      if (val > lim) begin
         return lim;
      end else begin
         return val;
      end
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Enable-qualified prescaler: emits one tick per PRESCALE enabled cycles.
// The phase is held while en is low and restarts from zero on clr.
module tick_prescaler #(
   parameter int unsigned PRESCALE = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] presc_r;

   // Phase counter advances only on enabled cycles and wraps after LAST.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_r <= {PW{1'b0}};
      end else if (clr) begin
         presc_r <= {PW{1'b0}};
      end else if (en) begin
         if (presc_r == LAST) begin
            presc_r <= {PW{1'b0}};
         end else begin
            presc_r <= presc_r + PW'(1);
         end
      end else begin
         presc_r <= presc_r;
      end
   end

   assign tick = en & (presc_r == LAST);

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with synchronous load, wrap/saturate limits,
// a terminal-count pulse and a sticky overflow flag.
module updown_mod_counter
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_VAL   = (2 ** WIDTH) - 1,
   parameter int unsigned RESET_VAL = 0,
   parameter int unsigned PRESCALE  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             sat_mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             ovf,
   output logic             zero
);

   localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] RESET_C = WIDTH'(RESET_VAL);
   localparam logic [WIDTH-1:0] ZERO_C  = {WIDTH{1'b0}};

   logic [WIDTH-1:0] count_r;
   logic             tc_r;
   logic             ovf_r;
   logic             tick_s;
   logic             step_s;
   logic             at_limit_s;
   logic             boundary_s;
   logic [WIDTH-1:0] load_clamped_s;
   logic [WIDTH-1:0] next_count_s;

   generate
      if (PRESCALE > 1) begin : g_presc
         tick_prescaler #(
            .PRESCALE(PRESCALE)
         ) u_presc (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .clr  (load),
            .tick (tick_s)
         );
      end else begin : g_no_presc
         assign tick_s = en;
      end
   endgenerate

   assign load_clamped_s = WIDTH'(clamp_to(32'(load_val), MAX_VAL));
   assign step_s         = en & tick_s & ~load;
   assign at_limit_s     = (up_dn == CNT_UP) ? (count_r == MAX_C) : (count_r == ZERO_C);
   assign boundary_s     = step_s & at_limit_s;

   // Next-count mux: stepping past a limit either wraps or sticks there.
   always_comb begin
      next_count_s = count_r;
      if (step_s) begin
         if (up_dn == CNT_UP) begin
            if (count_r == MAX_C) begin
               next_count_s = (sat_mode == MODE_SAT) ? MAX_C : ZERO_C;
            end else begin
               next_count_s = count_r + WIDTH'(1);
            end
         end else begin
            if (count_r == ZERO_C) begin
               next_count_s = (sat_mode == MODE_SAT) ? ZERO_C : MAX_C;
            end else begin
               next_count_s = count_r - WIDTH'(1);
            end
         end
      end else begin
         next_count_s = count_r;
      end
   end

   // Count, terminal-count and overflow registers; a boundary step beats clr_ovf.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= RESET_C;
         tc_r    <= 1'b0;
         ovf_r   <= 1'b0;
      end else if (load) begin
         count_r <= load_clamped_s;
         tc_r    <= 1'b0;
         ovf_r   <= clr_ovf ? 1'b0 : ovf_r;
      end else begin
         count_r <= next_count_s;
         tc_r    <= boundary_s;
         if (boundary_s) begin
            ovf_r <= 1'b1;
         end else if (clr_ovf) begin
            ovf_r <= 1'b0;
         end else begin
            ovf_r <= ovf_r;
         end
      end
   end

   assign count = count_r;
   assign tc    = tc_r;
   assign ovf   = ovf_r;
   assign zero  = (count_r == ZERO_C);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Drives two counter configurations from shared stimulus and compares both
// against an arithmetic reference model after every clock edge.
module tb_updown_mod_counter;

   logic       clk = 1'b0;
   logic       rst, en, up_dn, sat_mode, load, clr_ovf;
   logic [7:0] lv;

   logic [3:0] cnt_a;
   logic       tc_a, ovf_a, zero_a;
   logic [7:0] cnt_b;
   logic       tc_b, ovf_b, zero_b;

   int checks = 0;
   int errors = 0;

   // Reference model state: index 0 = config A, 1 = config B.
   int m_cnt[2], m_pre[2], m_tc[2], m_ovf[2];
   int mmax[2], mpsc[2], mrst[2], lvmask[2];

   always #5 clk = ~clk;

   // A: 4-bit, full range, no prescaler.
   updown_mod_counter #(.WIDTH(4)) dut_a (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
      .load(load), .load_val(lv[3:0]), .clr_ovf(clr_ovf),
      .count(cnt_a), .tc(tc_a), .ovf(ovf_a), .zero(zero_a)
   );

   // B: 8-bit, limit 9, non-zero reset value, prescale by 3.
   updown_mod_counter #(.WIDTH(8), .MAX_VAL(9), .RESET_VAL(5), .PRESCALE(3)) dut_b (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
      .load(load), .load_val(lv), .clr_ovf(clr_ovf),
      .count(cnt_b), .tc(tc_b), .ovf(ovf_b), .zero(zero_b)
   );

   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         int v;
         bit tick, bnd;
         v = int'(lv) & lvmask[i];
         if (rst) begin
            m_cnt[i] = mrst[i]; m_pre[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
         end else if (load) begin
            m_cnt[i] = (v > mmax[i]) ? mmax[i] : v;
            m_pre[i] = 0; m_tc[i] = 0;
            if (clr_ovf) m_ovf[i] = 0;
         end else begin
            tick = en && (m_pre[i] == mpsc[i] - 1);
            if (en) m_pre[i] = (m_pre[i] + 1) % mpsc[i];
            bnd = tick && (up_dn ? (m_cnt[i] == mmax[i]) : (m_cnt[i] == 0));
            if (tick) begin
               if (up_dn) m_cnt[i] = (m_cnt[i] == mmax[i]) ? (sat_mode ? mmax[i] : 0) : m_cnt[i] + 1;
               else       m_cnt[i] = (m_cnt[i] == 0) ? (sat_mode ? 0 : mmax[i]) : m_cnt[i] - 1;
            end
            m_tc[i] = bnd ? 1 : 0;
            if (bnd) m_ovf[i] = 1;
            else if (clr_ovf) m_ovf[i] = 0;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step_chk();
      @(posedge clk);
      model_edge();
      #1;
      chk("A.count", 32'(cnt_a), m_cnt[0]);
      chk("A.tc",    32'(tc_a),  m_tc[0]);
      chk("A.ovf",   32'(ovf_a), m_ovf[0]);
      chk("A.zero",  32'(zero_a), (m_cnt[0] == 0) ? 1 : 0);
      chk("B.count", 32'(cnt_b), m_cnt[1]);
      chk("B.tc",    32'(tc_b),  m_tc[1]);
      chk("B.ovf",   32'(ovf_b), m_ovf[1]);
      chk("B.zero",  32'(zero_b), (m_cnt[1] == 0) ? 1 : 0);
   endtask

   task automatic drive(input logic r, input logic e, input logic u, input logic s,
                        input logic l, input logic [7:0] v, input logic c);
      rst = r; en = e; up_dn = u; sat_mode = s; load = l; lv = v; clr_ovf = c;
   endtask

   initial begin
      mmax = '{15, 9}; mpsc = '{1, 3}; mrst = '{0, 5}; lvmask = '{15, 255};
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = mrst[i]; m_pre[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
      end

      // Reset state
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      step_chk();
      // Free-running up/wrap: A goes 0..15,0 with tc after the wrap
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      repeat (18) step_chk();
      // Load 2 then count down saturating; tc re-pulses while held at 0
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2, 1'b0);
      step_chk();
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
      repeat (12) step_chk();
      // Oversized load value with en high: clamped, no step, no tc
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd200, 1'b0);
      step_chk();
      // Prescaler phase hold across en low, then load restarting the phase
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      repeat (2) step_chk();
      en = 1'b0;
      repeat (2) step_chk();
      en = 1'b1;
      repeat (2) step_chk();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0);
      step_chk();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      repeat (4) step_chk();
      // Boundary step together with clr_ovf keeps ovf; clr_ovf alone clears it
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd255, 1'b1);
      step_chk();
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
      repeat (3) step_chk();
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
      step_chk();
      clr_ovf = 1'b0;
      step_chk();
      // Reset mid-count and mid-prescale with en high
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd7, 1'b0);
      step_chk();
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      step_chk();
      rst = 1'b1;
      step_chk();
      rst = 1'b0;
      repeat (4) step_chk();
      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
               1'($urandom), ($urandom_range(0, 9) == 0), 8'($urandom),
               ($urandom_range(0, 7) == 0));
         step_chk();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
